// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes and receiver/transmitter FSM states.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } uart_state_e;

endpackage

// File: rtl/uart_bit_sampler.sv
// RX line synchroniser, free-running bit-period counter and 3-sample mid-bit majority vote.
module uart_bit_sampler #(
  parameter int unsigned p_CLKs_PB = 217
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Rx_UART,
  input  logic clear,
  output logic line,
  output logic period_end_c,
  output logic bit_strobe,
  output logic bit_value
);

  localparam int unsigned CW = $clog2(p_CLKs_PB);
  localparam int unsigned H  = (p_CLKs_PB - 1) / 2;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [1:0]    smp;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_Rx_UART;
      sync2 <= sync1;
    end
  end

  // Bit-period counter: held at zero while cleared, wraps at the end of each bit period.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == CW'(p_CLKs_PB - 1))) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Capture the first two of the three mid-bit samples.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      smp <= '0;
    end else if (cnt == CW'(H - 1)) begin
      smp[0] <= sync2;
    end else if (cnt == CW'(H)) begin
      smp[1] <= sync2;
    end
  end

  // Third sample is the live synced line; the vote is decided at count H+1.
  assign line         = sync2;
  assign period_end_c = (cnt == CW'(p_CLKs_PB - 1));
  assign bit_strobe   = (cnt == CW'(H + 1));
  assign bit_value    = (smp[0] & smp[1]) | (smp[0] & sync2) | (smp[1] & sync2);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: frame FSM, parity/framing/break checks and a
// one-entry valid/ready holding register with overrun reporting.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned p_CLKs_PB   = 217,
  parameter int unsigned p_DATA_BITS = 8,
  parameter int unsigned p_PARITY    = 0,
  parameter int unsigned p_STOP_BITS = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_Rx_UART,
  output logic [p_DATA_BITS-1:0] o_Rx_Data,
  output logic                   o_Rx_Valid,
  input  logic                   i_Rx_Ready,
  output logic                   o_Parity_Err,
  output logic                   o_Frame_Err,
  output logic                   o_Break,
  output logic                   o_Overrun
);

  localparam int unsigned IW = $clog2(p_DATA_BITS + 1);

  uart_state_e            state;
  logic [p_DATA_BITS-1:0] shreg;
  logic [IW-1:0]          idx;
  logic                   perr_r;
  logic                   ferr_r;
  logic                   zero_r;

  logic line;
  logic period_end_c;
  logic bit_strobe;
  logic bit_value;
  logic done_c;
  logic break_c;
  logic ferr_c;
  logic clear_c;

  uart_bit_sampler #(
    .p_CLKs_PB (p_CLKs_PB)
  ) u_sampler (
    .i_Clk        (i_Clk),
    .i_Rst_n      (i_Rst_n),
    .i_Rx_UART    (i_Rx_UART),
    .clear        (clear_c),
    .line         (line),
    .period_end_c (period_end_c),
    .bit_strobe   (bit_strobe),
    .bit_value    (bit_value)
  );

  // Frame completes at the vote of the last stop bit; break needs every sampled bit at 0.
  assign done_c  = (state == ST_STOP) && bit_strobe && (idx == IW'(p_STOP_BITS - 1));
  assign break_c = zero_r & ~bit_value;
  assign ferr_c  = ferr_r | ~bit_value;
  // Counter is held idle while waiting for a start edge, while the line is low after a
  // break, and restarted on entry to WAIT_IDLE so a full high period is measured.
  assign clear_c = (state == ST_IDLE) ||
                   ((state == ST_WAIT_IDLE) && !line) ||
                   (done_c && break_c);

  // Frame FSM with shift register and accumulated error/zero tracking.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      idx    <= '0;
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!line) state <= ST_START;
        end
        ST_START: begin
          if (bit_strobe) begin
            if (bit_value) begin
              state <= ST_IDLE;
            end else begin
              state  <= ST_DATA;
              idx    <= '0;
              zero_r <= 1'b1;
              perr_r <= 1'b0;
              ferr_r <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (bit_strobe) begin
            shreg  <= {bit_value, shreg[p_DATA_BITS-1:1]};
            zero_r <= zero_r & ~bit_value;
            if (idx == IW'(p_DATA_BITS - 1)) begin
              idx   <= '0;
              state <= (p_PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (bit_strobe) begin
            perr_r <= ((^shreg) ^ bit_value) != (p_PARITY == PARITY_ODD);
            zero_r <= zero_r & ~bit_value;
            idx    <= '0;
            state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_strobe) begin
            ferr_r <= ferr_c;
            zero_r <= zero_r & ~bit_value;
            if (done_c) begin
              idx   <= '0;
              state <= break_c ? ST_WAIT_IDLE : ST_IDLE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (line && period_end_c) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Holding register and handshake; a same-cycle handshake frees the slot for the new word.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      o_Rx_Data    <= '0;
      o_Rx_Valid   <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      o_Break   <= 1'b0;
      o_Overrun <= 1'b0;
      if (done_c) begin
        if (!o_Rx_Valid || i_Rx_Ready) begin
          o_Rx_Data    <= shreg;
          o_Parity_Err <= perr_r;
          o_Frame_Err  <= ferr_c;
          o_Rx_Valid   <= 1'b1;
          o_Break      <= break_c;
        end else begin
          o_Overrun <= 1'b1;
        end
      end else if (o_Rx_Valid && i_Rx_Ready) begin
        o_Rx_Valid   <= 1'b0;
        o_Parity_Err <= 1'b0;
        o_Frame_Err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three instances (8N1, 8E1, 7N2) at 16 clocks per bit,
// a vector table of single frames plus hand-written multi-cycle sequences.
module tb_uart_rx_frame;

  localparam int unsigned CLKS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx;
  logic [2:0] ready;
  wire  [2:0] valid;
  wire  [2:0] perr;
  wire  [2:0] ferr;
  wire  [2:0] brk;
  wire  [2:0] ovr;
  wire  [7:0] data_a;
  wire  [7:0] data_b;
  wire  [6:0] data_c;
  wire  [8:0] data [3];

  assign data[0] = {1'b0, data_a};
  assign data[1] = {1'b0, data_b};
  assign data[2] = {2'b00, data_c};

  always #5 clk = ~clk;

  uart_rx_frame #(.p_CLKs_PB(CLKS), .p_DATA_BITS(8), .p_PARITY(0), .p_STOP_BITS(1)) u_8n1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Rx_UART(rx[0]), .o_Rx_Data(data_a), .o_Rx_Valid(valid[0]),
    .i_Rx_Ready(ready[0]), .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]), .o_Break(brk[0]),
    .o_Overrun(ovr[0]));

  uart_rx_frame #(.p_CLKs_PB(CLKS), .p_DATA_BITS(8), .p_PARITY(2), .p_STOP_BITS(1)) u_8e1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Rx_UART(rx[1]), .o_Rx_Data(data_b), .o_Rx_Valid(valid[1]),
    .i_Rx_Ready(ready[1]), .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]), .o_Break(brk[1]),
    .o_Overrun(ovr[1]));

  uart_rx_frame #(.p_CLKs_PB(CLKS), .p_DATA_BITS(7), .p_PARITY(0), .p_STOP_BITS(2)) u_7n2 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Rx_UART(rx[2]), .o_Rx_Data(data_c), .o_Rx_Valid(valid[2]),
    .i_Rx_Ready(ready[2]), .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]), .o_Break(brk[2]),
    .o_Overrun(ovr[2]));

  int checks = 0;
  int errors = 0;

  // Output monitor: counts valid cycles and pulses, keeps the last word seen.
  int         vcyc [3] = '{default: 0};
  int         bcnt [3] = '{default: 0};
  int         ocnt [3] = '{default: 0};
  logic [8:0] cap_data [3] = '{default: '0};
  logic       cap_perr [3] = '{default: 1'b0};
  logic       cap_ferr [3] = '{default: 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid[i]) begin
        vcyc[i]     <= vcyc[i] + 1;
        cap_data[i] <= data[i];
        cap_perr[i] <= perr[i];
        cap_ferr[i] <= ferr[i];
      end
      if (brk[i]) bcnt[i] <= bcnt[i] + 1;
      if (ovr[i]) ocnt[i] <= ocnt[i] + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input int sel, input logic b);
    rx[sel] = b;
    repeat (CLKS) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CLKS) @(negedge clk);
  endtask

  // Start, data LSB first, parity (8E1 only), stop bit(s); st[0] is the first stop bit.
  task automatic send_frame(input int sel, input logic [8:0] w, input logic pb, input logic [1:0] st);
    int nb = (sel == 2) ? 7 : 8;
    send_bit(sel, 1'b0);
    for (int k = 0; k < nb; k++) send_bit(sel, w[k]);
    if (sel == 1) send_bit(sel, pb);
    send_bit(sel, st[0]);
    if (sel == 2) send_bit(sel, st[1]);
    rx[sel] = 1'b1;
  endtask

  typedef struct {
    int         sel;
    logic [8:0] word;
    logic       pbit;
    logic [1:0] stops;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    int         s_v;
    int         s_b;
    int         s_o;
    logic [8:0] w5a;

    vecs[0]  = '{0, 9'h0A5, 1'b0, 2'b01, 9'h0A5, 1'b0, 1'b0};
    vecs[1]  = '{1, 9'h003, 1'b1, 2'b01, 9'h003, 1'b1, 1'b0};
    vecs[2]  = '{1, 9'h003, 1'b0, 2'b01, 9'h003, 1'b0, 1'b0};
    vecs[3]  = '{1, 9'h0FF, 1'b0, 2'b01, 9'h0FF, 1'b0, 1'b0};
    vecs[4]  = '{1, 9'h080, 1'b0, 2'b01, 9'h080, 1'b1, 1'b0};
    vecs[5]  = '{2, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};
    vecs[6]  = '{2, 9'h02A, 1'b0, 2'b01, 9'h02A, 1'b0, 1'b1};
    vecs[7]  = '{2, 9'h02A, 1'b0, 2'b10, 9'h02A, 1'b0, 1'b1};
    vecs[8]  = '{0, 9'h000, 1'b0, 2'b01, 9'h000, 1'b0, 1'b0};
    vecs[9]  = '{0, 9'h03C, 1'b0, 2'b00, 9'h03C, 1'b0, 1'b1};
    vecs[10] = '{0, 9'h0C3, 1'b0, 2'b01, 9'h0C3, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0;
    rx    = 3'b111;
    ready = 3'b111;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst valid[%0d]", i), 32'(valid[i]), 0);
      chk($sformatf("rst data[%0d]", i), 32'(data[i]), 0);
      chk($sformatf("rst flags[%0d]", i), {28'd0, perr[i], ferr[i], brk[i], ovr[i]}, 0);
    end
    rst_n = 1'b1;
    idle_bits(1);

    // Vector table: one frame each, consumer always ready
    for (int v = 0; v < NV; v++) begin
      s_v = vcyc[vecs[v].sel];
      s_b = bcnt[vecs[v].sel];
      send_frame(vecs[v].sel, vecs[v].word, vecs[v].pbit, vecs[v].stops);
      idle_bits(2);
      chk($sformatf("v%0d valid_cycles", v), 32'(vcyc[vecs[v].sel] - s_v), 1);
      chk($sformatf("v%0d data", v), 32'(cap_data[vecs[v].sel]), 32'(vecs[v].exp_data));
      chk($sformatf("v%0d parity_err", v), 32'(cap_perr[vecs[v].sel]), 32'(vecs[v].exp_perr));
      chk($sformatf("v%0d frame_err", v), 32'(cap_ferr[vecs[v].sel]), 32'(vecs[v].exp_ferr));
      chk($sformatf("v%0d break", v), 32'(bcnt[vecs[v].sel] - s_b), 0);
    end

    // False start: 4 low cycles never reach the mid-bit vote
    s_v = vcyc[0];
    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx[0] = 1'b1;
    idle_bits(3);
    chk("false_start no_valid", 32'(vcyc[0] - s_v), 0);

    // One-cycle high glitch at mid data bit 3 of 0x00 is outvoted
    s_v = vcyc[0];
    send_bit(0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        rx[0] = 1'b0;
        repeat (8) @(negedge clk);
        rx[0] = 1'b1;
        @(negedge clk);
        rx[0] = 1'b0;
        repeat (7) @(negedge clk);
      end else begin
        send_bit(0, 1'b0);
      end
    end
    send_bit(0, 1'b1);
    idle_bits(2);
    chk("glitch valid_cycles", 32'(vcyc[0] - s_v), 1);
    chk("glitch data", 32'(cap_data[0]), 32'h00);
    chk("glitch frame_err", 32'(cap_ferr[0]), 0);

    // Break on 7N2: line low for 3 frames, short high, low, long high, then a real frame
    s_v = vcyc[2];
    s_b = bcnt[2];
    rx[2] = 1'b0;
    repeat (3 * 10 * CLKS) @(negedge clk);
    rx[2] = 1'b1;
    repeat (10) @(negedge clk);
    rx[2] = 1'b0;
    repeat (40) @(negedge clk);
    rx[2] = 1'b1;
    repeat (30) @(negedge clk);
    send_frame(2, 9'h02B, 1'b0, 2'b11);
    idle_bits(2);
    chk("break pulses", 32'(bcnt[2] - s_b), 1);
    chk("break valid_cycles", 32'(vcyc[2] - s_v), 2);
    chk("after_break data", 32'(cap_data[2]), 32'h2B);
    chk("after_break frame_err", 32'(cap_ferr[2]), 0);

    // Overrun: consumer stalled, second word dropped
    ready[0] = 1'b0;
    s_o = ocnt[0];
    send_frame(0, 9'h011, 1'b0, 2'b01);
    send_frame(0, 9'h022, 1'b0, 2'b01);
    idle_bits(2);
    chk("overrun valid_held", 32'(valid[0]), 1);
    chk("overrun data_held", 32'(data_a), 32'h11);
    chk("overrun pulses", 32'(ocnt[0] - s_o), 1);
    ready[0] = 1'b1;
    @(negedge clk);
    chk("overrun valid_drop", 32'(valid[0]), 0);

    // Reset in the middle of data bit 4, then a clean frame
    w5a = 9'h05A;
    ready[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b01);
    idle_bits(1);
    chk("pre_reset valid", 32'(valid[0]), 1);
    send_bit(0, 1'b0);
    for (int k = 0; k < 4; k++) send_bit(0, w5a[k]);
    rx[0] = w5a[4];
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset valid", 32'(valid[0]), 0);
    chk("midreset data", 32'(data_a), 0);
    chk("midreset flags", {28'd0, perr[0], ferr[0], brk[0], ovr[0]}, 0);
    rst_n = 1'b1;
    rx[0] = 1'b1;
    ready[0] = 1'b1;
    s_v = vcyc[0];
    idle_bits(3);
    send_frame(0, w5a, 1'b0, 2'b01);
    idle_bits(2);
    chk("post_reset valid_cycles", 32'(vcyc[0] - s_v), 1);
    chk("post_reset data", 32'(cap_data[0]), 32'h5A);
    chk("post_reset errs", {30'd0, cap_perr[0], cap_ferr[0]}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
